// File: rtl/mcp_pkg.sv
// Shared types and constants for the MCP source-side feeder.
package mcp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } mcp_src_state_e;

    localparam int MCP_DW = 8;
    localparam int STAT_W = 16;

endpackage

// File: rtl/mcp_src_feeder_if.sv
// Upstream valid/ready stream plus the a-side send/ack signals of the MCP block.
interface mcp_src_feeder_if
    import mcp_pkg::*;
#(
    parameter int DW = MCP_DW
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] adatain;
    logic          asend;
    logic          aready;

    modport master (
        input  in_data, in_valid, aready,
        output in_ready, adatain, asend
    );

    modport slave (
        output in_data, in_valid, aready,
        input  in_ready, adatain, asend
    );
endinterface

// File: rtl/sync_fifo_1clk.sv
// Single-clock FIFO with wrap-bit pointers; head word is read combinationally.
module sync_fifo_1clk
    import mcp_pkg::*;
#(
    parameter  int DW    = MCP_DW,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          aclk,
    input  logic          arst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic [LW-1:0] level_q;
    logic [DW-1:0] mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr_q[AW-1:0]];
    assign level   = level_q;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge aclk) begin
        if (push_ok) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mcp_src_feeder.sv
// Source-side transmitter feeding buffered words into the MCP CDC block.
// Optional statistics counters are built when MCP_SRC_FEEDER_STATS_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for a buffered word and aready; pops and launches asend
// S_HOLD | one cycle after asend; aready ignored while the MCP ready drops
// S_WAIT | waiting for the MCP ack (aready high) before the next send
module mcp_src_feeder
    import mcp_pkg::*;
#(
    parameter  int DW    = MCP_DW,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          aclk,
    input  logic          arst_n,
    mcp_src_feeder_if.master bus,
    output logic [LW-1:0] fifo_level,
    output logic          idle
`ifdef MCP_SRC_FEEDER_STATS_EN
    ,
    output logic [STAT_W-1:0] sent_cnt,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    mcp_src_state_e state_q;
    mcp_src_state_e state_d;
    logic [DW-1:0]  adatain_q;
    logic [DW-1:0]  adatain_d;
    logic           asend_q;
    logic           asend_d;
    logic           pop;
    logic           push;
    logic [DW-1:0]  fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;

    // Pointer-derived full is the same condition as level == DEPTH.
    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;
    assign bus.adatain  = adatain_q;
    assign bus.asend    = asend_q;
    assign idle         = fifo_empty && (state_q == S_IDLE);

    sync_fifo_1clk #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk   (aclk),
        .arst_n (arst_n),
        .push   (push),
        .wdata  (bus.in_data),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            adatain_q <= '0;
            asend_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            adatain_q <= adatain_d;
            asend_q   <= asend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        adatain_d = adatain_q;
        asend_d   = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && bus.aready) begin
                    pop       = 1'b1;
                    adatain_d = fifo_rdata;
                    asend_d   = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.aready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MCP_SRC_FEEDER_STATS_EN
    // sent_cnt wraps naturally; stall_cnt saturates at all-ones.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            sent_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (asend_d) sent_cnt <= sent_cnt + 1'b1;
            if (!fifo_empty && (state_q == S_WAIT) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mcp_src_feeder.sv
// Directed self-checking bench for mcp_src_feeder (DW=8, DEPTH=4).
module tb_mcp_src_feeder;

    logic aclk;
    logic arst_n;
    logic [2:0] fifo_level;
    logic idle;
`ifdef MCP_SRC_FEEDER_STATS_EN
    logic [15:0] sent_cnt;
    logic [15:0] stall_cnt;
`endif

    mcp_src_feeder_if #(.DW(8)) bus ();

    mcp_src_feeder #(.DW(8), .DEPTH(4)) dut (
        .aclk       (aclk),
        .arst_n     (arst_n),
        .bus        (bus),
        .fifo_level (fifo_level),
        .idle       (idle)
`ifdef MCP_SRC_FEEDER_STATS_EN
        ,
        .sent_cnt   (sent_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int asend_cnt = 0;
    logic prev_asend = 1'b0;
    logic [7:0] sent_q[$];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Send monitor: records every word launched and checks the pulse is one cycle wide.
    always @(negedge aclk) begin
        if (arst_n && bus.asend) begin
            asend_cnt++;
            sent_q.push_back(bus.adatain);
            n_cmp++;
            if (prev_asend) begin
                n_err++;
                $display("FAIL asend_width asend high on two consecutive cycles, required single-cycle pulse");
            end
        end
        prev_asend = bus.asend;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL push_ready got %b expected 1 (word %h)", bus.in_ready, d);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bus.aready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (idle === 1'b1 && fifo_level === 3'd0) break;
            tick();
        end
        n_cmp++;
        if (idle !== 1'b1 || fifo_level !== 3'd0) begin
            n_err++;
            $display("FAIL %s_drain idle=%b level=%0d expected idle=1 level=0", tag, idle, fifo_level);
        end
    endtask

    task automatic test_reset();
        arst_n       = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.aready   = 1'b0;
        #3;
        n_cmp += 5;
        if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d expected 0", fifo_level); end
        if (bus.asend !== 1'b0) begin n_err++; $display("FAIL reset_asend got %b expected 0", bus.asend); end
        if (bus.adatain !== 8'h00) begin n_err++; $display("FAIL reset_adatain got %h expected 00", bus.adatain); end
        if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b expected 1", idle); end
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
        tick();
        tick();
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base;
        base = asend_cnt;
        sent_q.delete();
        bus.aready   = 1'b1;
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_cmp += 2;
        if (bus.asend !== 1'b0) begin n_err++; $display("FAIL single_early asend got %b expected 0", bus.asend); end
        if (fifo_level !== 3'd1) begin n_err++; $display("FAIL single_level1 got %0d expected 1", fifo_level); end
        tick();
        n_cmp += 3;
        if (bus.asend !== 1'b1) begin n_err++; $display("FAIL single_asend got %b expected 1", bus.asend); end
        if (bus.adatain !== 8'hA5) begin n_err++; $display("FAIL single_data got %h expected a5", bus.adatain); end
        if (fifo_level !== 3'd0) begin n_err++; $display("FAIL single_level0 got %0d expected 0", fifo_level); end
        bus.aready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp += 2;
            if (bus.asend !== 1'b0) begin n_err++; $display("FAIL single_hold_asend cycle %0d got %b expected 0", i, bus.asend); end
            if (bus.adatain !== 8'hA5) begin n_err++; $display("FAIL single_hold_data cycle %0d got %h expected a5", i, bus.adatain); end
        end
        wait_idle("single");
        n_cmp++;
        if (asend_cnt - base != 1) begin n_err++; $display("FAIL single_count got %0d expected 1", asend_cnt - base); end
    endtask

    task automatic test_burst_full();
        sent_q.delete();
        bus.aready = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) push_word(8'(i));
        bus.in_data  = 8'h05;
        bus.in_valid = 1'b1;
        tick();
        tick();
        n_cmp += 2;
        if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL burst_in_ready got %b expected 0", bus.in_ready); end
        if (fifo_level !== 3'd4) begin n_err++; $display("FAIL burst_level got %0d expected 4", fifo_level); end
        bus.aready = 1'b1;
        for (int i = 0; i < 60 && bus.in_valid; i++) begin
            automatic logic acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) bus.in_valid = 1'b0;
        end
        wait_idle("burst");
        n_cmp++;
        if (sent_q.size() != 5) begin
            n_err++;
            $display("FAIL burst_count got %0d expected 5", sent_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (sent_q[i] !== 8'(i + 1)) begin n_err++; $display("FAIL burst_order idx %0d got %h expected %h", i, sent_q[i], 8'(i + 1)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int last;
        int nsent;
        int glitch_at;
        int raise_at;
        logic [7:0] exp [3];
        exp[0] = 8'h10; exp[1] = 8'h11; exp[2] = 8'h12;
        sent_q.delete();
        bus.aready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push_word(exp[i]);
        last = -1; nsent = 0; glitch_at = -1; raise_at = -1;
        bus.aready = 1'b1;
        // MCP model: aready glitches high during HOLD, then low 6 cycles before the ack.
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (bus.asend === 1'b1) begin
                nsent++;
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != 9) begin n_err++; $display("FAIL b2b_spacing got %0d cycles expected 9", c - last); end
                end
                last = c;
                bus.aready = 1'b1;
                glitch_at = c + 1;
                raise_at = c + 7;
            end else if (c == glitch_at) begin
                bus.aready = 1'b0;
            end else if (c == raise_at) begin
                bus.aready = 1'b1;
            end
        end
        n_cmp++;
        if (nsent != 3) begin
            n_err++;
            $display("FAIL b2b_count got %0d expected 3", nsent);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (sent_q[i] !== exp[i]) begin n_err++; $display("FAIL b2b_order idx %0d got %h expected %h", i, sent_q[i], exp[i]); end
            end
        end
        wait_idle("b2b");
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] exp_q[$];
        int k;
        sent_q.delete();
        bus.aready = 1'b0;
        push_word(8'h20);
        push_word(8'h21);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h21);
        bus.in_data  = 8'h22;
        bus.in_valid = 1'b1;
        bus.aready   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        exp_q.push_back(8'h22);
        n_cmp++;
        if (fifo_level !== 3'd2) begin n_err++; $display("FAIL simul_level got %0d expected 2", fifo_level); end
        k = 0;
        for (int i = 0; i < 400 && k < 20; i++) begin
            automatic logic acc;
            if (!bus.in_valid) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'($urandom_range(0, 255));
            end
            bus.aready = 1'($urandom_range(0, 1));
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) begin
                exp_q.push_back(bus.in_data);
                bus.in_valid = 1'b0;
                k++;
            end
        end
        bus.in_valid = 1'b0;
        wait_idle("simul");
        n_cmp++;
        if (sent_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL simul_count got %0d expected %0d", sent_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (sent_q[i] !== exp_q[i]) begin n_err++; $display("FAIL simul_order idx %0d got %h expected %h", i, sent_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bus.aready = 1'b0;
        push_word(8'h31);
        push_word(8'h32);
        push_word(8'h33);
        bus.aready = 1'b1;
        tick();
        bus.aready = 1'b0;
        tick();
        tick();
        n_cmp += 2;
        if (fifo_level !== 3'd2) begin n_err++; $display("FAIL rmid_pre_level got %0d expected 2", fifo_level); end
        if (bus.adatain !== 8'h31) begin n_err++; $display("FAIL rmid_pre_data got %h expected 31", bus.adatain); end
        #2;
        arst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rmid_level got %0d expected 0", fifo_level); end
        if (bus.asend !== 1'b0) begin n_err++; $display("FAIL rmid_asend got %b expected 0", bus.asend); end
        if (bus.adatain !== 8'h00) begin n_err++; $display("FAIL rmid_adatain got %h expected 00", bus.adatain); end
        if (idle !== 1'b1) begin n_err++; $display("FAIL rmid_idle got %b expected 1", idle); end
        tick();
        tick();
        arst_n = 1'b1;
        bus.aready = 1'b1;
        base = asend_cnt;
        repeat (10) tick();
        n_cmp += 2;
        if (asend_cnt != base) begin n_err++; $display("FAIL rmid_no_send got %0d sends expected 0", asend_cnt - base); end
        if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rmid_post_level got %0d expected 0", fifo_level); end
    endtask

`ifdef MCP_SRC_FEEDER_STATS_EN
    task automatic test_stats();
        int k;
        n_cmp++;
        if (sent_cnt !== 16'd0) begin n_err++; $display("FAIL stats_reset got %0d expected 0", sent_cnt); end
        bus.aready = 1'b1;
        k = 0;
        for (int i = 0; i < 3000 && k < 300; i++) begin
            automatic logic acc;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(k);
            acc = bus.in_ready;
            tick();
            if (acc) k++;
        end
        bus.in_valid = 1'b0;
        wait_idle("stats");
        n_cmp++;
        if (sent_cnt !== 16'd300) begin n_err++; $display("FAIL stats_sent got %0d expected 300", sent_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst_full();
        test_back_to_back();
        test_simul_push_pop();
        test_reset_mid();
`ifdef MCP_SRC_FEEDER_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
